// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps a pc through a registered microcode ROM from start_addr to end_addr
// and issues each decoded word to the datapath, waiting for op_ack between instructions.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rom_addr presented, ROM read in flight
// ISSUE | rom_data valid, decode fields and pulse op_valid
// WAIT  | datapath executing, waiting for op_ack
// DONE  | one-cycle done pulse
module microcode_sequencer #(
  parameter int ADDR_W       = 9,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [25:0]       rom_data,
  output logic [5:0]        dst,
  output logic [5:0]        src_a,
  output logic [5:0]        src_b,
  output logic [7:0]        op,
  output logic              op_valid,
  input  logic              op_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [5:0]        dst_q, dst_d;
  logic [5:0]        src_a_q, src_a_d;
  logic [5:0]        src_b_q, src_b_d;
  logic [7:0]        op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              zero_halt;

  assign zero_halt = HALT_ON_ZERO && (rom_data == 26'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      end_q      <= '0;
      dst_q      <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      end_q      <= end_d;
      dst_q      <= dst_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: state_d = zero_halt ? S_DONE : S_WAIT;
      S_WAIT:  if (op_ack) state_d = last_q ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; pc only moves on the edges that enter FETCH.
  always_comb begin
    pc_d       = pc_q;
    end_d      = end_q;
    dst_d      = dst_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    err_d      = err_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d   = start_addr;
          end_d  = end_addr;
          err_d  = 1'b0;
          last_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (zero_halt) begin
          err_d = 1'b1;
        end else begin
          dst_d      = rom_data[25:20];
          src_a_d    = rom_data[19:14];
          src_b_d    = rom_data[13:8];
          op_d       = rom_data[7:0];
          op_valid_d = 1'b1;
          last_d     = (pc_q == end_q);
        end
      end
      S_WAIT: begin
        if (op_ack && !last_q) pc_d = pc_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign rom_addr = pc_q;
  assign dst      = dst_q;
  assign src_a    = src_a_q;
  assign src_b    = src_b_q;
  assign op       = op_q;
  assign op_valid = op_valid_q;
  assign err      = err_q;

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter: ADDR_W, 9, microcode ROM address width.
REQ-002 Parameter: HALT_ON_ZERO, 1, when 1 an all-zero instruction word terminates the program with an error.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to run a program segment.
REQ-006 Port: start_addr  input  ADDR_W  first instruction address, sampled with start.
REQ-007 Port: end_addr  input  ADDR_W  last instruction address (inclusive), sampled with start.
REQ-008 Port: rom_addr  output  ADDR_W  registered address to the registered microcode ROM.
REQ-009 Port: rom_data  input  26  ROM word, valid one cycle after rom_addr is presented.
REQ-010 Port: dst  output  6  registered rom_data[25:20].
REQ-011 Port: src_a  output  6  registered rom_data[19:14].
REQ-012 Port: src_b  output  6  registered rom_data[13:8].
REQ-013 Port: op  output  8  registered rom_data[7:0].
REQ-014 Port: op_valid  output  1  one-cycle pulse; dst/src_a/src_b/op carry a new instruction.
REQ-015 Port: op_ack  input  1  datapath has completed the current instruction.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse when the program segment ends.
REQ-018 Port: err  output  1  sticky halt-on-zero flag; cleared by the next accepted start or by reset.

Function
REQ-019 The state machine SHALL have the states IDLE, FETCH, ISSUE, WAIT and DONE, encoded in a state register.
REQ-020 IDLE: on start=1, load pc<=start_addr, latch end_addr, clear err, and go to FETCH; start is ignored in all other states.
REQ-021 rom_addr SHALL equal pc at all times; pc changes only on entry to FETCH.
REQ-022 FETCH SHALL last exactly one cycle and then go to ISSUE, giving the ROM its 1-cycle read latency.
REQ-023 ISSUE: capture the four fields from rom_data, pulse op_valid for this single cycle, set last=(pc==end_addr), and go to WAIT.
REQ-024 ISSUE with HALT_ON_ZERO=1 and rom_data==0: set err=1, do not assert op_valid, and go directly to DONE.
REQ-025 WAIT: op_ack is sampled only in this state; on op_ack go to DONE if last, else set pc<=pc+1 (mod 2^ADDR_W) and go to FETCH.
REQ-026 op_ack asserted in any state other than WAIT SHALL be ignored.
REQ-027 DONE: pulse done for one cycle and return to IDLE; the field outputs SHALL hold their last values.
REQ-028 The pc increment SHALL wrap from 2^ADDR_W-1 to 0; end_addr<start_addr is a legal segment that runs through the wrap.
REQ-029 start_addr==end_addr SHALL execute exactly one instruction.
REQ-030 Minimum cost per instruction is 3 cycles (FETCH, ISSUE, WAIT with op_ack in the first WAIT cycle).

Reset
REQ-031 While reset=1, the block SHALL enter IDLE with pc=0, rom_addr=0, dst=src_a=src_b=0, op=0, op_valid=0, busy=0, done=0, err=0, last=0.
REQ-032 Reset SHALL take priority over start and op_ack in the same cycle.
REQ-033 Reset asserted mid-program SHALL abort the program at the next edge with no done pulse.

Verification
REQ-034 Scenario, basic run: start_addr=0, end_addr=2, op_ack high whenever in WAIT, rom_data[0]=26'h30c042 -> rom_addr steps 0,1,2; three op_valid pulses; the first has dst=3, src_a=3, src_b=0, op=8'h42; done pulses 9 cycles after start; err=0.
REQ-035 Scenario, wrap: start_addr=510, end_addr=1 -> rom_addr sequence 510,511,0,1; four op_valid pulses; one done pulse.
REQ-036 Scenario, stall and spurious ack: op_ack held low for 5 WAIT cycles, and op_ack=1 driven during FETCH -> rom_addr and the fields stay stable throughout, there is no second op_valid, and the advance happens only on the WAIT-state ack.
REQ-037 Scenario, halt on zero: rom_data=0 at the second address -> one op_valid pulse, then err=1 and done; err stays 1 until the next start.
REQ-038 Scenario, start while busy and reset mid-run: start pulsed during WAIT is ignored; reset asserted in WAIT -> the next cycle shows IDLE with all outputs at their reset values and no done pulse.
